// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives PC to instr_mem, decodes 1/2-byte length, loads the IF/ID register.
// Latency: an instruction at PC appears on ifid_* one edge later; one bubble after a branch redirect.
// Backpressure: stall holds PC and all of IF/ID; branch_taken overrides stall; HALT freezes fetch until a branch.
module fetch_unit #(
    parameter int          PC_W         = 8,
    parameter logic [3:0]  TWO_BYTE_MIN = 4'hC,
    parameter logic [7:0]  HALT_OP      = 8'hF0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] PC,
    input  logic [7:0]      instr,
    input  logic [7:0]      next_byte,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic [7:0]      ifid_instr,
    output logic [7:0]      ifid_imm,
    output logic [PC_W-1:0] ifid_pc,
    output logic [PC_W-1:0] ifid_pc_next,
    output logic            ifid_valid,
    output logic            halted
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      ifid_instr_q, ifid_instr_d;
    logic [7:0]      ifid_imm_q, ifid_imm_d;
    logic [PC_W-1:0] ifid_pc_q, ifid_pc_d;
    logic [PC_W-1:0] ifid_pc_next_q, ifid_pc_next_d;
    logic            ifid_valid_q, ifid_valid_d;
    logic            halted_q, halted_d;

    logic            two_byte;
    logic [PC_W-1:0] pc_seq;

    // Length decode on the byte currently presented by instr_mem; sum wraps at PC_W bits.
    always_comb begin
        two_byte = (instr[7:4] >= TWO_BYTE_MIN);
        pc_seq   = two_byte ? (pc_q + PC_W'(2)) : (pc_q + PC_W'(1));
    end

    // Next-state and next-output selection: BOOT vector load, then branch > stall > fetch.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        ifid_instr_d   = ifid_instr_q;
        ifid_imm_d     = ifid_imm_q;
        ifid_pc_d      = ifid_pc_q;
        ifid_pc_next_d = ifid_pc_next_q;
        ifid_valid_d   = ifid_valid_q;
        halted_d       = halted_q;

        unique case (state_q)
            ST_BOOT: begin
                // mem[0] holds the reset vector; stall and branch are meaningless before the first fetch.
                pc_d         = PC_W'(instr);
                ifid_valid_d = 1'b0;
                state_d      = ST_RUN;
            end

            ST_RUN: begin
                if (branch_taken) begin
                    // Redirect inserts one bubble; the stale IF/ID payload is left in place.
                    pc_d         = branch_target;
                    ifid_valid_d = 1'b0;
                end else if (!stall) begin
                    ifid_instr_d   = instr;
                    ifid_pc_d      = pc_q;
                    ifid_imm_d     = two_byte ? next_byte : 8'h00;
                    ifid_pc_next_d = pc_seq;
                    ifid_valid_d   = 1'b1;
                    if (instr == HALT_OP) begin
                        // HALT goes down the pipe like any instruction but fetch stops on it.
                        state_d  = ST_HALTED;
                        halted_d = 1'b1;
                    end else begin
                        pc_d = pc_seq;
                    end
                end
            end

            ST_HALTED: begin
                ifid_valid_d = 1'b0;
                if (branch_taken) begin
                    // A late branch or interrupt wakes fetch; first fetch happens next cycle.
                    pc_d     = branch_target;
                    halted_d = 1'b0;
                    state_d  = ST_RUN;
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State and output registers; reset re-enters BOOT so the vector is reloaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_BOOT;
            pc_q           <= '0;
            ifid_instr_q   <= 8'h00;
            ifid_imm_q     <= 8'h00;
            ifid_pc_q      <= '0;
            ifid_pc_next_q <= '0;
            ifid_valid_q   <= 1'b0;
            halted_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            ifid_instr_q   <= ifid_instr_d;
            ifid_imm_q     <= ifid_imm_d;
            ifid_pc_q      <= ifid_pc_d;
            ifid_pc_next_q <= ifid_pc_next_d;
            ifid_valid_q   <= ifid_valid_d;
            halted_q       <= halted_d;
        end
    end

    assign PC           = pc_q;
    assign ifid_instr   = ifid_instr_q;
    assign ifid_imm     = ifid_imm_q;
    assign ifid_pc      = ifid_pc_q;
    assign ifid_pc_next = ifid_pc_next_q;
    assign ifid_valid   = ifid_valid_q;
    assign halted       = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table of per-cycle inputs and expected registered outputs,
// plus hand-written reset sequences. Memory is modelled as a 256-byte array read combinationally.
module tb_fetch_unit;

    logic       clk;
    logic       rst_n;
    logic [7:0] PC;
    logic [7:0] instr;
    logic [7:0] next_byte;
    logic       stall;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic [7:0] ifid_instr;
    logic [7:0] ifid_imm;
    logic [7:0] ifid_pc;
    logic [7:0] ifid_pc_next;
    logic       ifid_valid;
    logic       halted;

    logic [7:0] mem [256];
    logic [7:0] pc_p1;

    assign pc_p1     = PC + 8'd1;
    assign instr     = mem[PC];
    assign next_byte = mem[pc_p1];

    fetch_unit #(
        .PC_W         (8),
        .TWO_BYTE_MIN (4'hC),
        .HALT_OP      (8'hF0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .PC            (PC),
        .instr         (instr),
        .next_byte     (next_byte),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .ifid_instr    (ifid_instr),
        .ifid_imm      (ifid_imm),
        .ifid_pc       (ifid_pc),
        .ifid_pc_next  (ifid_pc_next),
        .ifid_valid    (ifid_valid),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       br;
        logic [7:0] tgt;
        logic [7:0] pc;
        logic       v;
        logic [7:0] ins;
        logic [7:0] imm;
        logic [7:0] ipc;
        logic [7:0] inx;
        logic       h;
        logic       chk_h;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic add(input logic st, input logic br, input logic [7:0] tgt,
                       input logic [7:0] pc, input logic v, input logic [7:0] ins,
                       input logic [7:0] imm, input logic [7:0] ipc, input logic [7:0] inx,
                       input logic h, input logic chk_h);
        vec_t e;
        e.st = st; e.br = br; e.tgt = tgt; e.pc = pc; e.v = v; e.ins = ins;
        e.imm = imm; e.ipc = ipc; e.inx = inx; e.h = h; e.chk_h = chk_h;
        vecs.push_back(e);
    endtask

    // Compares the full output bundle {PC,valid,instr,imm,pc,pc_next,halted}; halted optionally masked.
    task automatic check(input string name, input logic [7:0] pc, input logic v,
                         input logic [7:0] ins, input logic [7:0] imm, input logic [7:0] ipc,
                         input logic [7:0] inx, input logic h, input logic chk_h);
        logic [41:0] act;
        logic [41:0] exp;
        logic [41:0] msk;
        act = {PC, ifid_valid, ifid_instr, ifid_imm, ifid_pc, ifid_pc_next, halted};
        exp = {pc, v, ins, imm, ipc, inx, h};
        msk = chk_h ? {42{1'b1}} : {{41{1'b1}}, 1'b0};
        n_checks++;
        if ((act & msk) === (exp & msk)) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got pc=%h v=%b ins=%h imm=%h ipc=%h inx=%h halt=%b, want pc=%h v=%b ins=%h imm=%h ipc=%h inx=%h halt=%b%s",
                     name, PC, ifid_valid, ifid_instr, ifid_imm, ifid_pc, ifid_pc_next, halted,
                     pc, v, ins, imm, ipc, inx, h, chk_h ? "" : "(n/c)");
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h0A;              // reset vector
        mem[8'h0A] = 8'h21;
        mem[8'h0B] = 8'hC5;
        mem[8'h0C] = 8'h7A;
        mem[8'h0D] = 8'h22;
        mem[8'h30] = 8'h55;
        mem[8'hFF] = 8'hD0;
        mem[8'h20] = 8'hF0;              // HALT
        mem[8'h21] = 8'h99;
        mem[8'h40] = 8'h3C;

        //   st br  tgt    pc    v  ins    imm    ipc    inx    h  chk_h
        add(0, 0, 8'h00, 8'h0A, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1); // BOOT loads vector
        add(0, 0, 8'h00, 8'h0B, 1, 8'h21, 8'h00, 8'h0A, 8'h0B, 0, 1); // 1-byte fetch
        add(1, 0, 8'h00, 8'h0B, 1, 8'h21, 8'h00, 8'h0A, 8'h0B, 0, 1); // stall x3
        add(1, 0, 8'h00, 8'h0B, 1, 8'h21, 8'h00, 8'h0A, 8'h0B, 0, 1);
        add(1, 0, 8'h00, 8'h0B, 1, 8'h21, 8'h00, 8'h0A, 8'h0B, 0, 1);
        add(0, 0, 8'h00, 8'h0D, 1, 8'hC5, 8'h7A, 8'h0B, 8'h0D, 0, 1); // 2-byte fetch
        add(1, 1, 8'h30, 8'h30, 0, 8'hC5, 8'h7A, 8'h0B, 8'h0D, 0, 1); // branch beats stall
        add(0, 0, 8'h00, 8'h31, 1, 8'h55, 8'h00, 8'h30, 8'h31, 0, 1); // target latched
        add(0, 1, 8'hFF, 8'hFF, 0, 8'h55, 8'h00, 8'h30, 8'h31, 0, 1); // branch to FF
        add(0, 0, 8'h00, 8'h01, 1, 8'hD0, 8'h44, 8'hFF, 8'h01, 0, 1); // wrap, imm from mem[00]
        add(0, 1, 8'h20, 8'h20, 0, 8'hD0, 8'h44, 8'hFF, 8'h01, 0, 1); // branch to HALT
        add(0, 0, 8'h00, 8'h20, 1, 8'hF0, 8'h99, 8'h20, 8'h22, 0, 0); // HALT latched, PC held
        for (int k = 0; k < 10; k++)                                   // halted, stall ignored
            add(k[0] == 1'b0, 0, 8'h00, 8'h20, 0, 8'hF0, 8'h99, 8'h20, 8'h22, 1, 1);
        add(1, 1, 8'h40, 8'h40, 0, 8'hF0, 8'h99, 8'h20, 8'h22, 0, 1); // wake via branch
        add(0, 0, 8'h00, 8'h41, 1, 8'h3C, 8'h00, 8'h40, 8'h41, 0, 1); // fetch resumes

        rst_n         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 8'h00;
        step();
        step();
        check("reset", 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            stall         = vecs[i].st;
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].tgt;
            step();
            check($sformatf("vec%0d", i), vecs[i].pc, vecs[i].v, vecs[i].ins, vecs[i].imm,
                  vecs[i].ipc, vecs[i].inx, vecs[i].h, vecs[i].chk_h);
            // Reset vector consumed; reuse mem[00] as the immediate of the FF wrap case.
            if (i == 0) mem[8'h00] = 8'h44;
        end

        // Asynchronous reset mid-run, between edges.
        stall        = 1'b0;
        branch_taken = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1);
        mem[8'h00] = 8'h0A;
        @(negedge clk);
        rst_n         = 1'b1;
        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 8'h77;
        step();
        check("boot_ignores_br", 8'h0A, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1);
        stall        = 1'b0;
        branch_taken = 1'b0;
        step();
        check("reboot_fetch", 8'h0B, 1, 8'h21, 8'h00, 8'h0A, 8'h0B, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
